mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_pkg.sv | 40 ++++
 rtl/mul_div_unit_md_sign_fix.sv | 20 ++
 rtl/mul_div_unit.sv | 178 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative RV M-extension multiply/divide unit:
// funct3 op codes, FSM states and operand-signedness decode.
package mul_div_unit_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } md_state_e;

   function automatic logic op1_signed(input logic [2:0] op);
      logic s;
      case (op)
         MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: s = 1'b1;
         default:                                   s = 1'b0;
      endcase
      return s;
   endfunction

   function automatic logic op2_signed(input logic [2:0] op);
      logic s;
      case (op)
         MD_MUL, MD_MULH, MD_DIV, MD_REM: s = 1'b1;
         default:                         s = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mul_div_unit_md_sign_fix.sv
// Conditional two's-complement negation; takes magnitudes of signed operands
// on the way in and restores the result sign on the way out.
module md_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         negate,
   output logic [W-1:0] fixed
);

   // Negate when requested; the most negative value maps onto its own unsigned magnitude
   always_comb begin
      if (negate) begin
         fixed = ~value + {{(W-1){1'b0}}, 1'b1};
      end else begin
         fixed = value;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV M-extension unit: one-bit-per-cycle shift-add multiply and
// restoring divide on magnitudes, with sign correction when the result is loaded.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int  XLEN  = 32,
   localparam int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   output logic            busy,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);

   md_state_e         state_r, state_nxt_s;
   logic [2:0]        op_r;
   logic [XLEN-1:0]   mcand_r;
   logic [2*XLEN-1:0] prod_r;
   logic              neg_res_r;
   logic [CNT_W-1:0]  count_r;
   logic              busy_r, valid_r;
   logic [XLEN-1:0]   result_r;

   logic              sign_a_s, sign_b_s, accept_s, last_iter_s;
   logic              div_zero_s, overflow_s, special_s;
   logic [XLEN-1:0]   abs_a_s, abs_b_s, special_val_s, final_val_s, div_raw_s, div_fixed_s;
   logic [XLEN:0]     add_s, rem_sh_s, trial_s;
   logic [2*XLEN-1:0] mul_nxt_s, div_nxt_s, prod_nxt_s, prod_fixed_s;
   logic              busy_nxt_s, valid_nxt_s;
   logic [XLEN-1:0]   result_nxt_s;

   assign sign_a_s    = op1_signed(op) & operand1[XLEN-1];
   assign sign_b_s    = op2_signed(op) & operand2[XLEN-1];
   assign accept_s    = start & ~flush & (state_r == ST_IDLE);
   assign last_iter_s = (state_r == ST_RUN) && (count_r == CNT_W'(XLEN - 1));

   md_sign_fix #(.W(XLEN)) u_abs_a (.value(operand1), .negate(sign_a_s), .fixed(abs_a_s));
   md_sign_fix #(.W(XLEN)) u_abs_b (.value(operand2), .negate(sign_b_s), .fixed(abs_b_s));

   // Early-resolving divide cases and their architectural results
   always_comb begin
      div_zero_s = (operand2 == {XLEN{1'b0}});
      overflow_s = ((op == MD_DIV) || (op == MD_REM)) &&
                   (operand1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (operand2 == {XLEN{1'b1}});
      special_s  = op[2] & (div_zero_s | overflow_s);
      if (div_zero_s) begin
         special_val_s = op[1] ? operand1 : {XLEN{1'b1}};
      end else begin
         special_val_s = op[1] ? {XLEN{1'b0}} : operand1;
      end
   end

   // One iteration: shift-add for multiply, trial subtraction for divide
   always_comb begin
      add_s     = {1'b0, prod_r[2*XLEN-1:XLEN]} + (prod_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
      mul_nxt_s = {add_s, prod_r[XLEN-1:1]};
      rem_sh_s  = prod_r[2*XLEN-1:XLEN-1];
      // The shifted remainder is below twice the divisor, so bit XLEN doubles as the borrow
      trial_s   = rem_sh_s - {1'b0, mcand_r};
      if (!trial_s[XLEN]) begin
         div_nxt_s = {trial_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b1};
      end else begin
         div_nxt_s = {rem_sh_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b0};
      end
      prod_nxt_s = op_r[2] ? div_nxt_s : mul_nxt_s;
      div_raw_s  = op_r[1] ? prod_nxt_s[2*XLEN-1:XLEN] : prod_nxt_s[XLEN-1:0];
   end

   md_sign_fix #(.W(2*XLEN)) u_fix_prod (.value(prod_nxt_s), .negate(neg_res_r), .fixed(prod_fixed_s));
   md_sign_fix #(.W(XLEN))   u_fix_div  (.value(div_raw_s),  .negate(neg_res_r), .fixed(div_fixed_s));

   // Select the architectural result from the sign-corrected final iteration
   always_comb begin
      if (op_r[2]) begin
         final_val_s = div_fixed_s;
      end else if (op_r[1:0] == 2'b00) begin
         final_val_s = prod_fixed_s[XLEN-1:0];
      end else begin
         final_val_s = prod_fixed_s[2*XLEN-1:XLEN];
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; flush overrides everything, including a same-cycle start
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_nxt_s = special_s ? ST_DONE : ST_RUN;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (last_iter_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // FSM output decode, registered below so outputs change only on clock edges
   always_comb begin
      busy_nxt_s   = (state_nxt_s == ST_RUN);
      valid_nxt_s  = (state_nxt_s == ST_DONE);
      result_nxt_s = (state_r == ST_IDLE) ? special_val_s : final_val_s;
   end

   // Registered outputs; result only changes when a DONE cycle is entered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r   <= 1'b0;
         valid_r  <= 1'b0;
         result_r <= {XLEN{1'b0}};
      end else begin
         busy_r  <= busy_nxt_s;
         valid_r <= valid_nxt_s;
         if (valid_nxt_s) begin
            result_r <= result_nxt_s;
         end else begin
            result_r <= result_r;
         end
      end
   end

   // Datapath: operand capture on accept, one iteration per RUN cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r      <= 3'b000;
         mcand_r   <= {XLEN{1'b0}};
         prod_r    <= {(2*XLEN){1'b0}};
         neg_res_r <= 1'b0;
         count_r   <= {CNT_W{1'b0}};
      end else if (flush) begin
         count_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         op_r      <= op;
         mcand_r   <= op[2] ? abs_b_s : abs_a_s;
         prod_r    <= {{XLEN{1'b0}}, (op[2] ? abs_a_s : abs_b_s)};
         neg_res_r <= (op[2] & op[1]) ? sign_a_s : (sign_a_s ^ sign_b_s);
         count_r   <= {CNT_W{1'b0}};
      end else if (state_r == ST_RUN) begin
         prod_r  <= prod_nxt_s;
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign busy         = busy_r;
   assign result_valid = valid_r;
   assign result       = result_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: requests push hand-computed results,
// a negedge monitor pops and compares value and latency on every result_valid.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst, start, flush;
   logic [2:0]      op;
   logic [XLEN-1:0] operand1, operand2;
   logic            busy, result_valid;
   logic [XLEN-1:0] result;

   typedef struct {
      logic [31:0] value;
      int          lat;
      int          acc;
      string       name;
   } exp_t;

   exp_t        sb_q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [31:0] last_exp = 32'h0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mul_div_unit #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
      .operand1(operand1), .operand2(operand2),
      .busy(busy), .result_valid(result_valid), .result(result)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && result_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: result 0x%08h with nothing pending", result);
         end else begin
            e = sb_q.pop_front();
            check({e.name, "_result"}, result, e.value);
            check({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
         end
      end
   end

   // Drive a request for 'hold' edges; the first edge is the accept edge.
   task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv, input int lat,
                        input int hold);
      @(posedge clk); #1;
      op = o; operand1 = a; operand2 = b; start = 1'b1;
      sb_q.push_back('{value: expv, lat: lat, acc: cyc + 1, name: name});
      last_exp = expv;
      repeat (hold) @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Drive a one-cycle start pulse that must produce no result.
   task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      op = o; operand1 = a; operand2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((sb_q.size() != 0 || busy) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: still pending after %0d cycles, expected drained", name, n);
         sb_q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic run(input string name, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] expv, input int lat);
      issue(name, o, a, b, expv, lat, 1);
      wait_drain(name);
   endtask

   initial begin
      int bc;
      int n;
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000;
      operand1 = 32'h0; operand2 = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'b0, busy}, 32'h0);
      check("reset_valid", {31'b0, result_valid}, 32'h0);
      check("reset_result", result, 32'h0);
      rst = 1'b0;

      issue("mul_7x-3", MD_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1);
      bc = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) bc++;
         @(posedge clk); #1;
      end
      check("mul_busy_cycles", 32'(bc), 32'd32);
      wait_drain("mul_7x-3");

      run("mul_big",  MD_MUL,    32'h12345678, 32'h00000009, 32'hA3D70A38, 33);
      run("mulh",     MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
      run("mulhu",    MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run("mulhu_sh", MD_MULHU,  32'h12345678, 32'h00000010, 32'h00000001, 33);
      run("mulhsu",   MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      run("div",      MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run("rem",      MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run("divu",     MD_DIVU,   32'd100,      32'd7,        32'd14,       33);
      run("remu",     MD_REMU,   32'd100,      32'd7,        32'd2,        33);
      run("div_zero", MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run("div_ovf",  MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run("rem_ovf",  MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
      run("remu_zero", MD_REMU,  32'd5,        32'd0,        32'd5,        1);

      // Flush at RUN cycle 10: no result, busy drops, result held
      launch(MD_DIVU, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy", {31'b0, busy}, 32'h0);
      check("flush_result_held", result, last_exp);
      run("after_flush", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);

      // Asynchronous reset at RUN cycle 5
      launch(MD_MUL, 32'd3, 32'd5);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_busy", {31'b0, busy}, 32'h0);
      check("midrst_valid", {31'b0, result_valid}, 32'h0);
      check("midrst_result", result, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Start while busy must not restart the operation
      issue("busy_ignore", MD_MUL, 32'd3, 32'd4, 32'd12, 33, 1);
      repeat (5) @(posedge clk);
      launch(MD_DIVU, 32'd9, 32'd3);
      wait_drain("busy_ignore");

      // Start held through the DONE cycle must not launch a second request
      issue("done_ignore", MD_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 2);
      wait_drain("done_ignore");

      // Start and flush together: nothing accepted
      @(posedge clk); #1;
      op = MD_MUL; operand1 = 32'd2; operand2 = 32'd2; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("start_flush_busy", {31'b0, busy}, 32'h0);
      repeat (36) @(posedge clk);
      #1;

      // Back-to-back: second start accepted in the cycle after DONE
      issue("b2b_mul", MD_MUL, 32'd6, 32'd7, 32'd42, 33, 1);
      n = 0;
      while (!result_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("b2b_first_seen", {31'b0, result_valid}, 32'h1);
      issue("b2b_divu", MD_DIVU, 32'd1000, 32'd10, 32'd100, 33, 1);
      check("b2b_accept_busy", {31'b0, busy}, 32'h1);
      wait_drain("b2b_divu");

      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
